sample_packetizer: RTL and testbench
====================================

Name: sample_packetizer

Overview:
- Upstream feeder for the FX2 transfer stage.
- Buffers 16-bit receiver samples in an internal FIFO and raises packet_rdy once a full packet is stored.
- Serves words to the FX2 side on rd_req with one-cycle registered latency.
- Tracks overflow and underrun as sticky flags for the host status path.

Parameters:
- DATA_WIDTH, 16, sample and output word width
- ADDR_WIDTH, 10, FIFO address bits; depth = 2^ADDR_WIDTH = 1024 words
- PACKET_WORDS, 256, words that must be buffered before packet_rdy asserts
- HOLDOFF_CYCLES, 2, cycles packet_rdy is held low after a transfer ends

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- clear_flags  in  1  synchronous pulse; clears overflow and underrun
- sample_valid  in  1  write strobe for sample_data
- sample_data  in  DATA_WIDTH  sample from the receiver datapath
- packet_rdy  out  1  at least PACKET_WORDS words are buffered and the block is armed
- rd_req  in  1  read strobe from the FX2 stage; one word per high cycle
- dout  out  DATA_WIDTH  registered read data
- dout_valid  out  1  dout carries a word for the rd_req sampled on the previous edge
- fill_count  out  ADDR_WIDTH+1  words currently stored, 0..2^ADDR_WIDTH
- overflow  out  1  sticky: a sample was dropped because the FIFO was full
- underrun  out  1  sticky: a read was made with the FIFO empty

Behaviour:
- Reset (async, any time, including mid-transfer):
  - FIFO pointers and fill_count = 0, state = IDLE.
  - packet_rdy = 0, dout = 0, dout_valid = 0, overflow = 0, underrun = 0.
  - Buffered data is discarded.
- Write side:
  - sample_valid with fill_count < depth: store the word; write pointer wraps modulo depth.
  - sample_valid when full: drop the word; overflow <= 1 on the next edge; pointers unchanged.
- Pop and fill_count:
  - A pop occurs only when rd_req = 1, state is READY or XFER, and fill_count > 0.
  - fill_count = writes - pops. A simultaneous accepted write and pop leaves it unchanged.
  - A write into a full FIFO is dropped even if a pop happens in the same cycle, since fullness is judged before the edge.
- Read data:
  - Each rd_req cycle sampled high in READY or XFER gives dout_valid = 1 on the following cycle.
  - If a pop occurred, dout = popped word.
  - If the FIFO was empty, dout = 0 and underrun <= 1.
  - In all other cycles dout_valid = 0 and dout holds its last value.
- clear_flags: overflow and underrun <= 0. If clear_flags coincides with a new overflow or underrun event, the set wins.
- State machine (registered):
  - IDLE: packet_rdy = 0. When fill_count >= PACKET_WORDS -> READY.
  - READY: packet_rdy = 1. rd_req = 1 -> XFER; packet_rdy falls on the same edge and the first pop happens on that edge.
  - XFER: packet_rdy = 0; one pop per rd_req cycle. rd_req = 0 -> HOLD, and the word counter is cleared.
  - HOLD: packet_rdy = 0 for HOLDOFF_CYCLES cycles, then -> IDLE. Lets the FX2 stage return to idle before re-arming.
- Transfer length:
  - Set by the consumer. Reading more than PACKET_WORDS words is legal and pops further words while data remains.
  - Reading fewer leaves the remainder in place for the next packet.
- rd_req in IDLE or HOLD: ignored. No pop, no dout_valid, no underrun.
- Latency:
  - sample_valid to fill_count update: 1 cycle.
  - fill_count reaching PACKET_WORDS to packet_rdy high: 1 cycle.
  - rd_req to dout_valid: 1 cycle.
- Storage: inferred dual-port RAM, synchronous read. No combinational path from rd_req to dout.

Test Plan:
- Reset, then write 255 ramp words 0..254 -> fill_count = 255, packet_rdy = 0. Write word 255 -> packet_rdy = 1 one cycle after fill_count = 256.
- From READY, hold rd_req high 256 cycles -> dout_valid pulses 256 times with dout = 0..255 in order. packet_rdy drops on the first rd_req edge. fill_count = 0 at the end, underrun = 0.
- Same as the previous case with rd_req held 258 cycles (FX2 over-read) -> last two outputs dout = 0 with dout_valid = 1, underrun = 1. After rd_req falls, packet_rdy stays 0 for 2 cycles, then the FSM returns to IDLE. clear_flags -> underrun = 0.
- Fill all 1024 words, then write 3 more -> fill_count = 1024, overflow = 1. Read out 1024 words -> data 0..1023 with no corruption; pointers wrap correctly on a second fill of 300 words.
- Sustained write every cycle while reading every cycle in XFER with fill_count = 512 -> fill_count stays 512 and output order matches input order.
- Assert reset mid-XFER after 100 reads -> all outputs go to their reset values immediately. After release, fill_count = 0 and packet_rdy = 0 until 256 new words arrive.

Source files
------------

// File: rtl/sample_packetizer.sv
// sample_packetizer
// Buffers receiver samples in a FIFO and hands them to the FX2 transfer stage
// one packet at a time. packet_rdy rises once PACKET_WORDS words are stored.
// The consumer then reads one word per rd_req cycle. Overflow and underrun
// are reported as sticky flags.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   clear_flags   synchronous pulse clearing overflow/underrun
//   sample_valid  write strobe for sample_data
//   sample_data   receiver sample
//   packet_rdy    a full packet is buffered and the block is armed
//   rd_req        read strobe, one word per high cycle
//   dout          registered read data (0 for an underrun read)
//   dout_valid    dout answers the rd_req sampled on the previous edge
//   fill_count    words currently stored, 0..2^ADDR_WIDTH
//   overflow      sticky: a sample was dropped while full
//   underrun      sticky: a read was served while empty
module sample_packetizer #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned PACKET_WORDS   = 256,
    parameter int unsigned HOLDOFF_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_flags,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample_data,
    output logic                  packet_rdy,
    input  logic                  rd_req,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic [ADDR_WIDTH:0]   fill_count,
    output logic                  overflow,
    output logic                  underrun
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned HW    = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

    localparam logic [ADDR_WIDTH:0]   FILL_FULL  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   FILL_PKT   = (ADDR_WIDTH+1)'(PACKET_WORDS);
    localparam logic [ADDR_WIDTH:0]   FILL_ZERO  = (ADDR_WIDTH+1)'(0);
    localparam logic [ADDR_WIDTH:0]   FILL_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
    localparam logic [HW-1:0]         HOLD_ZERO  = HW'(0);
    localparam logic [HW-1:0]         HOLD_ONE   = HW'(1);
    localparam logic [HW-1:0]         HOLD_LAST  = HW'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [HW-1:0]           hold_cnt_q, hold_cnt_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]     fill_q, fill_d;
    logic                    ovf_q, ovf_d;
    logic                    unr_q, unr_d;
    logic                    packet_rdy_q;
    logic                    dout_valid_q;
    logic [DATA_WIDTH-1:0]   dout_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic serving_s, full_s, empty_s;
    logic wr_acc_s, ovf_evt_s, rd_acc_s, pop_s, unr_evt_s;

    // Datapath control: fullness/emptiness are judged on the pre-edge count.
    always_comb begin
        serving_s = (state_q == ST_READY) || (state_q == ST_XFER);
        full_s    = (fill_q == FILL_FULL);
        empty_s   = (fill_q == FILL_ZERO);
        wr_acc_s  = sample_valid && !full_s;
        ovf_evt_s = sample_valid && full_s;
        rd_acc_s  = rd_req && serving_s;
        pop_s     = rd_acc_s && !empty_s;
        unr_evt_s = rd_acc_s && empty_s;

        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_acc_s, pop_s})
            2'b10:   fill_d = fill_q + FILL_ONE;
            2'b01:   fill_d = fill_q - FILL_ONE;
            default: fill_d = fill_q;
        endcase

        // A new event takes priority over clear_flags.
        if (ovf_evt_s) begin
            ovf_d = 1'b1;
        end else if (clear_flags) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        if (unr_evt_s) begin
            unr_d = 1'b1;
        end else if (clear_flags) begin
            unr_d = 1'b0;
        end else begin
            unr_d = unr_q;
        end
    end

    // Packet FSM next state: arm on a full packet, serve, then hold off.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (fill_q >= FILL_PKT) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READY: begin
                if (rd_req) begin
                    state_d = ST_XFER;
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_XFER: begin
                if (!rd_req) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = HOLD_ZERO;
                end else begin
                    state_d = ST_XFER;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_ONE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                hold_cnt_d = HOLD_ZERO;
            end
        endcase
    end

    // Control and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            hold_cnt_q   <= HOLD_ZERO;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_q       <= FILL_ZERO;
            ovf_q        <= 1'b0;
            unr_q        <= 1'b0;
            packet_rdy_q <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_q       <= fill_d;
            ovf_q        <= ovf_d;
            unr_q        <= unr_d;
            packet_rdy_q <= (state_d == ST_READY);
            dout_valid_q <= rd_acc_s;
        end
    end

    // Registered read port: popped word, zero on underrun, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q <= '0;
        end else if (pop_s) begin
            dout_q <= mem_q[rd_ptr_q];
        end else if (unr_evt_s) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_q;
        end
    end

    // Sample storage write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[wr_ptr_q] <= sample_data;
        end
    end

    assign packet_rdy = packet_rdy_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign fill_count = fill_q;
    assign overflow   = ovf_q;
    assign underrun   = unr_q;

endmodule

// File: tb/tb_sample_packetizer.sv
// Bench for sample_packetizer: directed scenarios plus random traffic, all
// checked every cycle against a queue-based model of the packetizer rules.
module tb_sample_packetizer;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear_flags;
    logic        sample_valid;
    logic [15:0] sample_data;
    logic        packet_rdy;
    logic        rd_req;
    logic [15:0] dout;
    logic        dout_valid;
    logic [10:0] fill_count;
    logic        overflow;
    logic        underrun;

    always #5 clk = ~clk;

    sample_packetizer dut (
        .clk          (clk),
        .reset        (reset),
        .clear_flags  (clear_flags),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .packet_rdy   (packet_rdy),
        .rd_req       (rd_req),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .fill_count   (fill_count),
        .overflow     (overflow),
        .underrun     (underrun)
    );

    // Reference model state
    logic [15:0] mq[$];
    logic [15:0] m_dout;
    logic        m_dv, m_ovf, m_unr;
    logic        m_rdy;   // armed: a packet is offered
    logic        m_busy;  // consumer is reading a packet
    int          m_hold;  // remaining holdoff cycles

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_dout = 16'd0; m_dv = 1'b0; m_ovf = 1'b0; m_unr = 1'b0;
        m_rdy = 1'b0; m_busy = 1'b0; m_hold = 0;
    endtask

    task automatic model_step(input logic sv, input logic [15:0] d, input logic rd, input logic clr);
        int  old_fill;
        logic ev_o, ev_u;
        old_fill = mq.size();
        ev_o = 1'b0; ev_u = 1'b0;
        m_dv = 1'b0;
        if (rd && (m_rdy || m_busy)) begin
            m_dv = 1'b1;
            if (old_fill > 0) m_dout = mq.pop_front();
            else begin m_dout = 16'd0; ev_u = 1'b1; end
        end
        if (sv) begin
            if (old_fill < 1024) mq.push_back(d);
            else ev_o = 1'b1;
        end
        m_ovf = (m_ovf && !clr) || ev_o;
        m_unr = (m_unr && !clr) || ev_u;
        if (m_hold > 0) m_hold = m_hold - 1;
        else if (m_busy) begin
            if (!rd) begin m_busy = 1'b0; m_hold = 2; end
        end else if (m_rdy) begin
            if (rd) begin m_rdy = 1'b0; m_busy = 1'b1; end
        end else if (old_fill >= 256) m_rdy = 1'b1;
    endtask

    // Called at a negedge: drive inputs, step model at the edge, return at next negedge.
    task automatic tick(input logic sv, input logic [15:0] d, input logic rd, input logic clr);
        sample_valid = sv; sample_data = d; rd_req = rd; clear_flags = clr;
        @(posedge clk);
        model_step(sv, d, rd, clr);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        #2;
        reset = 1'b1;
        sample_valid = 1'b0; sample_data = 16'd0; rd_req = 1'b0; clear_flags = 1'b0;
        model_reset();
        #1;
        check("rst_packet_rdy", 32'(packet_rdy), 32'd0);
        check("rst_dout",       32'(dout),       32'd0);
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_fill",       32'(fill_count), 32'd0);
        check("rst_overflow",   32'(overflow),   32'd0);
        check("rst_underrun",   32'(underrun),   32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        check("cmp_packet_rdy", 32'(packet_rdy), 32'(m_rdy));
        check("cmp_dout_valid", 32'(dout_valid), 32'(m_dv));
        check("cmp_dout",       32'(dout),       32'(m_dout));
        check("cmp_fill",       32'(fill_count), 32'(mq.size()));
        check("cmp_overflow",   32'(overflow),   32'(m_ovf));
        check("cmp_underrun",   32'(underrun),   32'(m_unr));
    end

    initial begin
        reset = 1'b1;
        sample_valid = 1'b0; sample_data = 16'd0; rd_req = 1'b0; clear_flags = 1'b0;
        model_reset();
        @(negedge clk);
        apply_reset();

        // Arming threshold
        for (int i = 0; i < 255; i++) tick(1'b1, 16'(i), 1'b0, 1'b0);
        check("fill_255", 32'(fill_count), 32'd255);
        check("rdy_at_255", 32'(packet_rdy), 32'd0);
        tick(1'b1, 16'd255, 1'b0, 1'b0);
        check("fill_256", 32'(fill_count), 32'd256);
        check("rdy_same_cycle_256", 32'(packet_rdy), 32'd0);
        tick(1'b0, 16'd0, 1'b0, 1'b0);
        check("rdy_after_256", 32'(packet_rdy), 32'd1);

        // Exact packet read
        for (int i = 0; i < 256; i++) begin
            tick(1'b0, 16'd0, 1'b1, 1'b0);
            if (i == 0) check("rdy_drop_first_rd", 32'(packet_rdy), 32'd0);
            check("pkt_dv", 32'(dout_valid), 32'd1);
            check("pkt_dout", 32'(dout), 32'(i));
        end
        check("pkt_fill_end", 32'(fill_count), 32'd0);
        check("pkt_unr_end", 32'(underrun), 32'd0);
        for (int i = 0; i < 3; i++) tick(1'b0, 16'd0, 1'b0, 1'b0);

        // Over-read by two words
        for (int i = 0; i < 256; i++) tick(1'b1, 16'(i), 1'b0, 1'b0);
        tick(1'b0, 16'd0, 1'b0, 1'b0);
        for (int i = 0; i < 258; i++) begin
            tick(1'b0, 16'd0, 1'b1, 1'b0);
            check("ovr_dv", 32'(dout_valid), 32'd1);
            check("ovr_dout", 32'(dout), (i < 256) ? 32'(i) : 32'd0);
        end
        check("ovr_underrun", 32'(underrun), 32'd1);
        tick(1'b0, 16'd0, 1'b0, 1'b1);
        check("clr_underrun", 32'(underrun), 32'd0);
        check("clr_dv_low", 32'(dout_valid), 32'd0);
        for (int i = 0; i < 2; i++) tick(1'b0, 16'd0, 1'b0, 1'b0);

        // Holdoff after a short transfer with data left over
        for (int i = 0; i < 300; i++) tick(1'b1, 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b0, 16'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 16'd0, 1'b0, 1'b0);
            check("holdoff_low", 32'(packet_rdy), 32'd0);
        end
        tick(1'b0, 16'd0, 1'b0, 1'b0);
        check("rearm_high", 32'(packet_rdy), 32'd1);
        check("rearm_fill", 32'(fill_count), 32'd290);
        apply_reset();

        // Full FIFO, overflow, wrap
        for (int i = 0; i < 1027; i++) tick(1'b1, 16'(i), 1'b0, 1'b0);
        check("full_fill", 32'(fill_count), 32'd1024);
        check("full_overflow", 32'(overflow), 32'd1);
        for (int i = 0; i < 1024; i++) begin
            tick(1'b0, 16'd0, 1'b1, 1'b0);
            check("full_dout", 32'(dout), 32'(i));
        end
        for (int i = 0; i < 3; i++) tick(1'b0, 16'd0, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) tick(1'b1, 16'(5000 + i), 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            tick(1'b0, 16'd0, 1'b1, 1'b0);
            check("wrap_dout", 32'(dout), 32'(5000 + i));
        end
        check("wrap_fill", 32'(fill_count), 32'd0);
        for (int i = 0; i < 3; i++) tick(1'b0, 16'd0, 1'b0, 1'b0);

        // Streaming: write and read every cycle at fill 512
        for (int i = 0; i < 512; i++) tick(1'b1, 16'(20000 + i), 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) begin
            tick(1'b1, 16'(30000 + i), 1'b1, 1'b0);
            check("stream_dout", 32'(dout), 32'(20000 + i));
        end
        check("stream_fill", 32'(fill_count), 32'd512);
        for (int i = 0; i < 3; i++) tick(1'b0, 16'd0, 1'b0, 1'b0);
        apply_reset();

        // Reset in the middle of a transfer
        for (int i = 0; i < 256; i++) tick(1'b1, 16'(i), 1'b0, 1'b0);
        tick(1'b0, 16'd0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) tick(1'b0, 16'd0, 1'b1, 1'b0);
        apply_reset();
        for (int i = 0; i < 255; i++) tick(1'b1, 16'(700 + i), 1'b0, 1'b0);
        tick(1'b0, 16'd0, 1'b0, 1'b0);
        check("post_rst_rdy_255", 32'(packet_rdy), 32'd0);
        tick(1'b1, 16'd955, 1'b0, 1'b0);
        tick(1'b0, 16'd0, 1'b0, 1'b0);
        check("post_rst_rdy_256", 32'(packet_rdy), 32'd1);
        apply_reset();

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                 16'($urandom),
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
